// File: rtl/miner_rx_assembler.sv
// Byte-stream to work-unit assembler feeding the miner core: collects FRAME_BYTES bytes,
// then publishes them as one stable rx_data word with a one-cycle data_ready pulse.
module miner_rx_assembler #(
    parameter int FRAME_BYTES = 108,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_valid,
    input  logic                     rx_error,
    input  logic                     miner_busy,
    output logic [FRAME_BYTES*8-1:0] rx_data,
    output logic                     data_ready,
    output logic                     frame_err,
    output logic                     overrun,
    output logic [7:0]               frames_ok
);

    localparam int W  = FRAME_BYTES * 8;
    localparam int CW = $clog2(FRAME_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_HOLD,
        S_PUBLISH
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_shreg;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_tmo      <= '0;
            rx_data    <= '0;
            data_ready <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            frames_ok  <= '0;
        end else begin
            data_ready <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        r_shreg <= {r_shreg[W-9:0], rx_byte};
                        r_cnt   <= CW'(1);
                        r_tmo   <= '0;
                        r_state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (rx_error) begin
                        frame_err <= 1'b1;
                        r_cnt     <= '0;
                        r_tmo     <= '0;
                        r_state   <= S_IDLE;
                    end else if (rx_valid) begin
                        r_shreg <= {r_shreg[W-9:0], rx_byte};
                        r_cnt   <= r_cnt + CW'(1);
                        r_tmo   <= '0;
                        if (r_cnt == CW'(FRAME_BYTES - 1))
                            r_state <= miner_busy ? S_HOLD : S_PUBLISH;
                    end else if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
                        // this idle cycle is the TIMEOUT_CYC-th in a row
                        frame_err <= 1'b1;
                        r_cnt     <= '0;
                        r_tmo     <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_HOLD: begin
                    if (rx_valid)
                        overrun <= 1'b1;
                    if (!miner_busy)
                        r_state <= S_PUBLISH;
                end
                S_PUBLISH: begin
                    rx_data    <= r_shreg;
                    data_ready <= 1'b1;
                    frames_ok  <= frames_ok + 8'd1;
                    r_tmo      <= '0;
                    // a byte arriving now already starts the next frame
                    if (rx_valid) begin
                        r_shreg <= {r_shreg[W-9:0], rx_byte};
                        r_cnt   <= CW'(1);
                        r_state <= S_COLLECT;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_miner_rx_assembler.sv
// Bench for miner_rx_assembler: scenario table, hand-written corner sequences and random
// traffic, all checked cycle by cycle against a queue-based reference model.
module tb_miner_rx_assembler;

    localparam int FB = 108;
    localparam int T  = 40;
    localparam int W  = FB * 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [7:0]     rx_byte = '0;
    logic           rx_valid = 1'b0;
    logic           rx_error = 1'b0;
    logic           miner_busy = 1'b0;
    logic [W-1:0]   rx_data;
    logic           data_ready, frame_err, overrun;
    logic [7:0]     frames_ok;

    miner_rx_assembler #(.FRAME_BYTES(FB), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_error(rx_error),
        .miner_busy(miner_busy), .rx_data(rx_data), .data_ready(data_ready),
        .frame_err(frame_err), .overrun(overrun), .frames_ok(frames_ok)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_dr = 0, cnt_fe = 0, cnt_ov = 0;
    bit chk_en = 1'b0;

    logic [7:0] f1 [FB];
    logic [7:0] f2 [FB];
    logic [7:0] fr [FB];

    // reference model state
    logic [7:0]   q[$];
    bit           m_full = 1'b0, m_go = 1'b0;
    int           m_idle = 0;
    logic [W-1:0] m_frame = '0, m_rx = '0;
    logic         m_dr = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
    logic [7:0]   m_frames = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_wide(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got hi=%h lo=%h expected hi=%h lo=%h at %0t", name,
                     act[W-1:W-64], act[63:0], exp[W-1:W-64], exp[63:0], $time);
        end
    endtask

    function automatic logic [W-1:0] pack_a(input logic [7:0] b [FB]);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < FB; i++) v[W-1-8*i -: 8] = b[i];
        return v;
    endfunction

    function automatic logic [W-1:0] pack_q(input logic [7:0] b [$]);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < FB; i++) v[W-1-8*i -: 8] = b[i];
        return v;
    endfunction

    // Model: a frame is a list of bytes; a completed frame waits until the miner is free
    // and is handed over on the following edge.
    task automatic model_step();
        if (rst) begin
            q.delete();
            m_full = 1'b0; m_go = 1'b0; m_idle = 0;
            m_frame = '0; m_rx = '0; m_frames = '0;
            m_dr = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        end else begin
            m_dr = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
            if (m_go) begin
                m_rx = m_frame; m_dr = 1'b1; m_frames = m_frames + 8'd1;
                m_go = 1'b0; m_full = 1'b0;
                if (rx_valid) begin q.push_back(rx_byte); m_idle = 0; end
            end else if (m_full) begin
                if (rx_valid) m_ov = 1'b1;
                if (!miner_busy) m_go = 1'b1;
            end else if (q.size() == 0) begin
                if (rx_valid) begin q.push_back(rx_byte); m_idle = 0; end
            end else if (rx_error) begin
                q.delete(); m_fe = 1'b1;
            end else if (rx_valid) begin
                q.push_back(rx_byte); m_idle = 0;
                if (q.size() == FB) begin
                    m_frame = pack_q(q); q.delete();
                    m_full = 1'b1; m_go = !miner_busy;
                end
            end else begin
                m_idle++;
                if (m_idle == T) begin q.delete(); m_fe = 1'b1; m_idle = 0; end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            if (data_ready === 1'b1) cnt_dr++;
            if (frame_err === 1'b1)  cnt_fe++;
            if (overrun === 1'b1)    cnt_ov++;
            chk("cycle_outputs", {data_ready, frame_err, overrun, frames_ok}, {m_dr, m_fe, m_ov, m_frames});
            chk_wide("cycle_rx_data", rx_data, m_rx);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        rx_error = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_arr(input logic [7:0] b [FB], input int from, input int to);
        for (int i = from; i < to; i++) send_byte(b[i]);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0; rx_error = 1'b0; miner_busy = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cnt_dr = 0; cnt_fe = 0; cnt_ov = 0;
    endtask

    task automatic init_frames();
        for (int i = 0; i < FB; i++) begin
            f1[i] = 8'((i * 37 + 11) & 255);
            f2[i] = 8'((i * 53 + 7) & 255);
        end
        f1[0] = 8'h01; f1[1] = 8'h00; f1[2] = 8'h00; f1[3] = 8'h00;
        f1[4] = 8'hb7; f1[5] = 8'hbd;
        f1[72] = 8'hff; f1[73] = 8'hff; f1[74] = 8'h00; f1[75] = 8'h1d;
        for (int i = 76; i < FB; i++) f1[i] = 8'h00;
        f1[80] = 8'hff; f1[81] = 8'hff;
        f2[0] = 8'h01; f2[1] = 8'h45; f2[2] = 8'h67; f2[3] = 8'h89;
        f2[72] = 8'hf2; f2[73] = 8'hb9; f2[74] = 8'h44; f2[75] = 8'h1a;
        for (int i = 76; i < FB; i++) f2[i] = 8'h00;
        f2[76] = 8'hf0;
    endtask

    typedef enum int { K_PLAIN, K_TIMEOUT, K_NEARTO, K_ERR, K_ERRV, K_IDLEERR, K_BUSY, K_B2B } kind_t;

    typedef struct {
        kind_t kind;
        int    pre;
        int    extra;
        int    exp_dr;
        int    exp_fe;
        int    exp_ov;
        int    exp_frames;
        bit    final_f2;
    } row_t;

    task automatic run_row(input int idx, input row_t r);
        do_reset();
        case (r.kind)
            K_PLAIN: begin
                send_arr(f1, 0, FB);
                chk($sformatf("row%0d_dr_at_last", idx), data_ready, 1'b0);
                tick();
                chk($sformatf("row%0d_dr_next", idx), data_ready, 1'b1);
                tick();
                chk($sformatf("row%0d_dr_fall", idx), data_ready, 1'b0);
            end
            K_TIMEOUT: begin
                send_arr(f2, 0, r.pre);
                idle(T + 2);
                send_arr(f1, 0, FB);
            end
            K_NEARTO: begin
                send_arr(f1, 0, r.pre);
                idle(T - 1);
                send_arr(f1, r.pre, FB);
            end
            K_ERR: begin
                send_arr(f2, 0, r.pre);
                rx_error = 1'b1; tick(); rx_error = 1'b0;
                send_arr(f1, 0, FB);
            end
            K_ERRV: begin
                send_arr(f2, 0, r.pre);
                rx_error = 1'b1; rx_valid = 1'b1; rx_byte = 8'haa;
                tick();
                rx_error = 1'b0; rx_valid = 1'b0;
                send_arr(f1, 0, FB);
            end
            K_IDLEERR: begin
                rx_error = 1'b1; tick(); rx_error = 1'b0;
                send_arr(f1, 0, FB);
            end
            K_BUSY: begin
                send_arr(f1, 0, FB);
                idle(3);
                miner_busy = 1'b1;
                send_arr(f2, 0, FB);
                for (int i = 0; i < r.extra; i++) send_byte(8'hee);
                idle(5);
                chk_wide($sformatf("row%0d_hold_rx", idx), rx_data, pack_a(f1));
                chk($sformatf("row%0d_hold_dr", idx), cnt_dr, 1);
                miner_busy = 1'b0;
                tick();
                chk($sformatf("row%0d_hold_pub", idx), data_ready, 1'b0);
                tick();
                chk($sformatf("row%0d_hold_dr1", idx), data_ready, 1'b1);
            end
            K_B2B: begin
                send_arr(f1, 0, FB);
                send_arr(f2, 0, FB);
            end
            default: ;
        endcase
        idle(4);
        chk($sformatf("row%0d_dr_count", idx), cnt_dr, r.exp_dr);
        chk($sformatf("row%0d_fe_count", idx), cnt_fe, r.exp_fe);
        chk($sformatf("row%0d_ov_count", idx), cnt_ov, r.exp_ov);
        chk($sformatf("row%0d_frames_ok", idx), frames_ok, r.exp_frames);
        chk_wide($sformatf("row%0d_rx_data", idx), rx_data, r.final_f2 ? pack_a(f2) : pack_a(f1));
    endtask

    initial begin
        row_t rows [9];
        rows[0] = '{K_PLAIN,    0, 0, 1, 0, 0, 1, 1'b0};
        rows[1] = '{K_TIMEOUT, 50, 0, 1, 1, 0, 1, 1'b0};
        rows[2] = '{K_TIMEOUT,107, 0, 1, 1, 0, 1, 1'b0};
        rows[3] = '{K_NEARTO,  50, 0, 1, 0, 0, 1, 1'b0};
        rows[4] = '{K_ERR,     30, 0, 1, 1, 0, 1, 1'b0};
        rows[5] = '{K_ERRV,     1, 0, 1, 1, 0, 1, 1'b0};
        rows[6] = '{K_IDLEERR,  0, 0, 1, 0, 0, 1, 1'b0};
        rows[7] = '{K_BUSY,     0, 3, 2, 0, 3, 2, 1'b1};
        rows[8] = '{K_B2B,      0, 0, 2, 0, 0, 2, 1'b1};

        init_frames();
        #2 rst = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("reset_outputs", {data_ready, frame_err, overrun, frames_ok}, '0);
        chk_wide("reset_rx_data", rx_data, '0);
        tick();
        tick();
        rst = 1'b0;

        foreach (rows[i]) run_row(i, rows[i]);

        // asynchronous reset in the middle of a frame
        do_reset();
        send_arr(f2, 0, FB);
        idle(3);
        send_arr(f1, 0, 60);
        #2 rst = 1'b1;
        #1;
        chk("arst_outputs", {data_ready, frame_err, overrun, frames_ok}, '0);
        chk_wide("arst_rx_data", rx_data, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        send_arr(f1, 0, FB);
        idle(4);
        chk("arst_frames_ok", frames_ok, 8'd1);
        chk("arst_fe_count", cnt_fe, 0);
        chk_wide("arst_rx_after", rx_data, pack_a(f1));

        // frames_ok wrap 255 -> 0
        do_reset();
        for (int k = 0; k < 255; k++) begin
            for (int i = 0; i < FB; i++) fr[i] = 8'($urandom);
            send_arr(fr, 0, FB);
        end
        idle(4);
        chk("wrap_255", frames_ok, 8'd255);
        chk_wide("wrap_rx_255", rx_data, pack_a(fr));
        for (int i = 0; i < FB; i++) fr[i] = 8'($urandom);
        send_arr(fr, 0, FB);
        idle(4);
        chk("wrap_0", frames_ok, 8'd0);
        chk("wrap_dr_count", cnt_dr, 256);
        chk_wide("wrap_rx_0", rx_data, pack_a(fr));

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 399) == 0) idle($urandom_range(T - 2, T + 2));
            if ($urandom_range(0, 99) == 0) miner_busy = ~miner_busy;
            rx_valid = ($urandom_range(0, 7) != 0);
            rx_byte  = 8'($urandom);
            rx_error = ($urandom_range(0, 599) == 0);
            tick();
        end
        miner_busy = 1'b0;
        idle(6);
        chk("random_frames_seen", cnt_dr > 10, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
